// File: rtl/dff_response_checker.sv
// Observing-side monitor for a D flip-flop with active-low set/reset: predicts Q from the
// stimulus sampled at each edge, compares one edge later, and keeps statistics plus a sticky verdict.
module dff_response_checker #(
  parameter int CNT_W        = 8,
  parameter int WARMUP       = 2,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             en,
  input  logic             clr,
  input  logic             d,
  input  logic             sn,
  input  logic             rn,
  input  logic             q,
  input  logic             qn,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ill_cnt,
  output logic [CNT_W-1:0] first_fail,
  output logic             fail,
  output logic             pass
);
  typedef enum logic [1:0] {IDLE = 2'd0, WARM = 2'd1, CHECK = 2'd2, HALT = 2'd3} st_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  st_e        st, st_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       exp_q, exp_valid;
  logic       legal, sample_q, run, cmp, mismatch;

  // sn=rn=0 is the only illegal combination; set dominates otherwise when active
  assign legal    = sn | rn;
  assign sample_q = ~sn ? 1'b1 : (~rn ? 1'b0 : d);
  assign run      = en & ((st == WARM) | (st == CHECK));
  assign cmp      = en & (st == CHECK) & exp_valid;
  assign mismatch = cmp & ((q != exp_q) | (qn == exp_q));

  always_comb begin
    st_nxt   = st;
    wcnt_nxt = wcnt;
    case (st)
      IDLE:  if (en) begin
               st_nxt   = WARM;
               wcnt_nxt = 4'(WARMUP - 1);
             end
      WARM:  if (en) begin
               if (wcnt == 4'd0) st_nxt = CHECK;
               else              wcnt_nxt = wcnt - 4'd1;
             end
      CHECK: if (mismatch && STOP_ON_FAIL) st_nxt = HALT;
      default: ;
    endcase
  end

  always_ff @(posedge C) begin
    if (R || clr) begin
      st         <= IDLE;
      wcnt       <= '0;
      exp_q      <= 1'b0;
      exp_valid  <= 1'b0;
      chk_cnt    <= '0;
      err_cnt    <= '0;
      ill_cnt    <= '0;
      first_fail <= '0;
      fail       <= 1'b0;
    end else begin
      st   <= st_nxt;
      wcnt <= wcnt_nxt;
      // a paused or illegal cycle leaves nothing to compare on the next edge
      if (st != HALT) begin
        exp_valid <= en & legal;
        exp_q     <= legal & sample_q;
      end
      if (run && !legal && ill_cnt != CNT_MAX) ill_cnt <= ill_cnt + 1'b1;
      if (cmp && chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + 1'b1;
      if (mismatch) begin
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        if (!fail) begin
          first_fail <= chk_cnt;
          fail       <= 1'b1;
        end
      end
    end
  end

  assign state = st;
  assign pass  = (st == CHECK) && (chk_cnt != '0) && !fail;

endmodule

// File: tb/tb_dff_response_checker.sv
// Drives a modelled flip-flop response (optionally corrupted) into three checker configurations
// and compares every output each cycle against a behavioural per-edge model.
module tb_dff_response_checker;
  localparam int ND     = 3;
  localparam int WARMUP = 2;

  logic C = 1'b0, R = 1'b1, en = 1'b0, clr = 1'b0;
  logic d = 1'b0, sn = 1'b1, rn = 1'b1, q = 1'b0, qn = 1'b1;
  always #5 C = ~C;

  logic [1:0] st0, st1, st2;
  logic [7:0] chk0, err0, ill0, ff0, chk1, err1, ill1, ff1;
  logic [3:0] chk2, err2, ill2, ff2;
  logic       fail0, pass0, fail1, pass1, fail2, pass2;

  dff_response_checker #(.CNT_W(8), .WARMUP(WARMUP), .STOP_ON_FAIL(1'b0)) u_dut0 (
    .C(C), .R(R), .en(en), .clr(clr), .d(d), .sn(sn), .rn(rn), .q(q), .qn(qn),
    .state(st0), .chk_cnt(chk0), .err_cnt(err0), .ill_cnt(ill0), .first_fail(ff0),
    .fail(fail0), .pass(pass0));
  dff_response_checker #(.CNT_W(8), .WARMUP(WARMUP), .STOP_ON_FAIL(1'b1)) u_dut1 (
    .C(C), .R(R), .en(en), .clr(clr), .d(d), .sn(sn), .rn(rn), .q(q), .qn(qn),
    .state(st1), .chk_cnt(chk1), .err_cnt(err1), .ill_cnt(ill1), .first_fail(ff1),
    .fail(fail1), .pass(pass1));
  dff_response_checker #(.CNT_W(4), .WARMUP(WARMUP), .STOP_ON_FAIL(1'b0)) u_dut2 (
    .C(C), .R(R), .en(en), .clr(clr), .d(d), .sn(sn), .rn(rn), .q(q), .qn(qn),
    .state(st2), .chk_cnt(chk2), .err_cnt(err2), .ill_cnt(ill2), .first_fail(ff2),
    .fail(fail2), .pass(pass2));

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] chk, err, ill, ff;
    logic       fail, pass;
  } obs_t;
  obs_t ob [ND];
  assign ob[0] = {st0, chk0, err0, ill0, ff0, fail0, pass0};
  assign ob[1] = {st1, chk1, err1, ill1, ff1, fail1, pass1};
  assign ob[2] = {st2, 4'd0, chk2, 4'd0, err2, 4'd0, ill2, 4'd0, ff2, fail2, pass2};

  int cw   [ND] = '{8, 8, 4};
  bit stop [ND] = '{1'b0, 1'b1, 1'b0};

  // model: mode 0 idle, 1 warming, 2 checking, 3 halted; pv/pq = prediction from last edge
  int m_st [ND], m_wc [ND], m_chk [ND], m_err [ND], m_ill [ND], m_ff [ND];
  bit m_fail [ND], m_pv [ND], m_pq [ND];

  int n_chk = 0, n_pass = 0;
  bit armed = 1'b0, tog = 1'b0;
  bit pd = 1'b0, psn = 1'b1, prn = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
  endtask

  function automatic int sat(int v, int w);
    return (v >= (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic model_edge(input int i);
    bit legal, mm;
    int pre;
    if (R || clr) begin
      m_st[i] = 0; m_wc[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_ill[i] = 0; m_ff[i] = 0;
      m_fail[i] = 0; m_pv[i] = 0; m_pq[i] = 0;
      return;
    end
    if (m_st[i] == 3) return;
    if (!en) begin
      m_pv[i] = 0;
      return;
    end
    legal = sn || rn;
    pre   = m_st[i];
    if ((pre == 1 || pre == 2) && !legal) m_ill[i] = sat(m_ill[i], cw[i]);
    case (pre)
      0: begin m_st[i] = 1; m_wc[i] = WARMUP - 1; end
      1: if (m_wc[i] == 0) m_st[i] = 2; else m_wc[i]--;
      2: if (m_pv[i]) begin
           mm = (q !== m_pq[i]) || (qn !== !m_pq[i]);
           if (mm) begin
             m_err[i] = sat(m_err[i], cw[i]);
             if (!m_fail[i]) begin m_ff[i] = m_chk[i]; m_fail[i] = 1; end
             if (stop[i]) m_st[i] = 3;
           end
           m_chk[i] = sat(m_chk[i], cw[i]);
         end
      default: ;
    endcase
    m_pv[i] = legal;
    m_pq[i] = !sn ? 1'b1 : (!rn ? 1'b0 : d);
  endtask

  task automatic cmp_all();
    for (int i = 0; i < ND; i++) begin
      check($sformatf("state%0d", i), ob[i].st,   m_st[i]);
      check($sformatf("chk%0d", i),   ob[i].chk,  m_chk[i]);
      check($sformatf("err%0d", i),   ob[i].err,  m_err[i]);
      check($sformatf("ill%0d", i),   ob[i].ill,  m_ill[i]);
      check($sformatf("ff%0d", i),    ob[i].ff,   m_ff[i]);
      check($sformatf("fail%0d", i),  ob[i].fail, m_fail[i]);
      check($sformatf("pass%0d", i),  ob[i].pass, (m_st[i] == 2) && (m_chk[i] != 0) && !m_fail[i]);
    end
  endtask

  // q/qn answer the stimulus sampled at the previous edge; fault inverts q
  task automatic cycle(input bit e, input bit c, input bit r, input bit dd, input bit s,
                       input bit rr, input bit fault);
    bit gq;
    @(negedge C);
    if (armed) cmp_all();
    gq = !psn ? 1'b1 : (!prn ? 1'b0 : pd);
    qn = (!psn && !prn) ? 1'b1 : !gq;
    q  = gq ^ fault;
    R = r; clr = c; en = e; d = dd; sn = s; rn = rr;
    @(posedge C);
    pd = dd; psn = s; prn = rr;
    for (int i = 0; i < ND; i++) model_edge(i);
    armed = 1'b1;
  endtask

  // mode 0 normal toggling D, 1 set, 2 reset, 3 illegal
  task automatic run(input int n, input int mode, input bit e, input bit fault);
    for (int k = 0; k < n; k++) begin
      case (mode)
        0: begin cycle(e, 0, 0, tog, 1, 1, fault); tog = !tog; end
        1: cycle(e, 0, 0, 1'b0, 0, 1, fault);
        2: cycle(e, 0, 0, 1'b1, 1, 0, fault);
        default: cycle(e, 0, 0, 1'($urandom_range(0, 1)), 0, 0, fault);
      endcase
    end
  endtask

  int c0, s1c, s1e;

  initial begin
    cycle(0, 0, 1, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 1, 1, 0);
    #1;
    check("rst_state", ob[0].st, 0);
    check("rst_chk", ob[0].chk, 0);
    check("rst_fail", ob[0].fail, 0);

    run(11, 0, 1, 0);
    #1;
    check("norm_chk", ob[0].chk, 8);
    check("norm_err", ob[0].err, 0);
    check("norm_pass", ob[0].pass, 1);
    check("norm_state", ob[0].st, 2);

    run(4, 1, 1, 0);
    run(4, 2, 1, 0);
    #1;
    check("sr_chk", ob[0].chk, 16);
    check("sr_err", ob[0].err, 0);

    run(3, 3, 1, 0);
    #1;
    check("ill_cnt", ob[0].ill, 3);
    check("ill_fail", ob[0].fail, 0);
    run(3, 0, 1, 0);

    #1 c0 = int'(ob[0].chk);
    run(4, 0, 0, 0);
    #1 check("pause_hold", ob[0].chk, c0);
    run(1, 0, 1, 0);
    #1 check("resume_skip", ob[0].chk, c0);
    run(1, 0, 1, 0);
    #1 check("resume_inc", ob[0].chk, c0 + 1);

    cycle(1, 1, 0, 0, 1, 1, 0);
    run(8, 1, 1, 0);
    run(2, 1, 1, 1);
    #1;
    check("flt_err0", ob[0].err, 2);
    check("flt_ff0", ob[0].ff, 5);
    check("flt_fail0", ob[0].fail, 1);
    check("flt_pass0", ob[0].pass, 0);
    check("flt_err1", ob[1].err, 1);
    check("flt_state1", ob[1].st, 3);
    s1c = int'(ob[1].chk); s1e = int'(ob[1].err);
    run(10, 0, 1, 0);
    #1;
    check("halt_chk1", ob[1].chk, s1c);
    check("halt_err1", ob[1].err, s1e);
    check("halt_state1", ob[1].st, 3);
    check("cont_chk0", ob[0].chk, 17);

    cycle(1, 1, 0, 0, 1, 1, 0);
    run(23, 0, 1, 0);
    #1;
    check("sat_chk2", ob[2].chk, 15);
    check("sat_chk0", ob[0].chk, 20);
    cycle(1, 1, 0, tog, 1, 1, 1);
    #1;
    check("clr_state2", ob[2].st, 0);
    check("clr_chk2", ob[2].chk, 0);
    check("clr_err0", ob[0].err, 0);
    check("clr_fail0", ob[0].fail, 0);

    for (int k = 0; k < 2000; k++)
      cycle(($urandom % 10) != 0, ($urandom % 100) == 0, ($urandom % 200) == 0,
            1'($urandom_range(0, 1)), ($urandom % 8) != 0, ($urandom % 8) != 0,
            ($urandom % 30) == 0);
    cycle(0, 0, 0, 0, 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
